// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core definitions: ROB geometry, data widths and the ROB entry layout
// used by the ROB controller, reservation stations and CDB logic.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int TAG_W     = 3;
  localparam int REG_W     = 4;
  localparam int DATA_W    = 16;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } rob_entry_t;

  // Pointers are exactly TAG_W bits wide, so the increment wraps modulo ROB_DEPTH.
  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] t);
    return t + TAG_W'(1);
  endfunction

endpackage

// File: rtl/rob_commit_ctrl.sv
// Reorder-buffer controller: hands out tags at issue, marks entries done from the CDB and
// retires completed entries in program order through a registered commit port.
module rob_commit_ctrl
  import tomasulo_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [REG_W-1:0]  issue_dest,
  output logic              issue_ready,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              flush,
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_tag,
  output logic [REG_W-1:0]  commit_dest,
  output logic [DATA_W-1:0] commit_data,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty
);

  rob_entry_t       rob [ROB_DEPTH];
  logic [TAG_W-1:0] head_p;
  logic [TAG_W-1:0] tail_p;

  logic do_issue;
  logic do_commit;
  logic cdb_hit;

  assign full        = (count == (TAG_W+1)'(ROB_DEPTH));
  assign empty       = (count == '0);
  assign issue_ready = !full;
  assign issue_tag   = tail_p;

  // Commit looks only at state registered before this edge, so a CDB write cannot bypass into it.
  assign do_issue  = issue_valid && !full;
  assign do_commit = rob[head_p].busy && rob[head_p].done;
  assign cdb_hit   = cdb_valid && rob[cdb_tag].busy;

  always_ff @(posedge clk1) begin
    if (!rst_n || flush) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        rob[i] <= '0;
      end
      head_p       <= '0;
      tail_p       <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_tag   <= '0;
      commit_dest  <= '0;
      commit_data  <= '0;
    end else begin
      if (cdb_hit) begin
        rob[cdb_tag].done <= 1'b1;
        rob[cdb_tag].data <= cdb_data;
      end

      // Written after the CDB update so a late broadcast to the retiring entry cannot keep it alive.
      commit_valid <= do_commit;
      if (do_commit) begin
        rob[head_p].busy <= 1'b0;
        rob[head_p].done <= 1'b0;
        commit_tag       <= head_p;
        commit_dest      <= rob[head_p].dest;
        commit_data      <= rob[head_p].data;
        head_p           <= tag_inc(head_p);
      end

      if (do_issue) begin
        rob[tail_p].busy <= 1'b1;
        rob[tail_p].done <= 1'b0;
        rob[tail_p].dest <= issue_dest;
        tail_p           <= tag_inc(tail_p);
      end

      case ({do_issue, do_commit})
        2'b10:   count <= count + (TAG_W+1)'(1);
        2'b01:   count <= count - (TAG_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Self-checking bench for rob_commit_ctrl: directed scenarios pinned with literal values,
// then randomized traffic compared every cycle against a queue-based program-order model.
module tb_rob_commit_ctrl;
  import tomasulo_pkg::*;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              issue_valid;
  logic [REG_W-1:0]  issue_dest;
  logic              issue_ready;
  logic [TAG_W-1:0]  issue_tag;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              flush;
  logic              commit_valid;
  logic [TAG_W-1:0]  commit_tag;
  logic [REG_W-1:0]  commit_dest;
  logic [DATA_W-1:0] commit_data;
  logic [TAG_W:0]    count;
  logic              full;
  logic              empty;

  always #5 clk1 = ~clk1;

  rob_commit_ctrl dut (
    .clk1(clk1), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_dest(issue_dest),
    .issue_ready(issue_ready), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .flush(flush),
    .commit_valid(commit_valid), .commit_tag(commit_tag),
    .commit_dest(commit_dest), .commit_data(commit_data),
    .count(count), .full(full), .empty(empty)
  );

  // Model: in-flight instructions in program order; oldest at index 0.
  typedef struct {
    int                tag;
    logic [REG_W-1:0]  dest;
    bit                done;
    logic [DATA_W-1:0] data;
  } mentry_t;

  mentry_t           mq[$];
  int                nextTag;
  bit                expValid;
  int                expTag;
  logic [REG_W-1:0]  expDest;
  logic [DATA_W-1:0] expData;

  int vectors     = 0;
  int miscompares = 0;
  int commitLog[$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelEdge();
    int      sizeBefore;
    mentry_t e;
    sizeBefore = mq.size();
    if (!rst_n || flush) begin
      mq.delete();
      nextTag  = 0;
      expValid = 1'b0;
      expTag   = 0;
      expDest  = '0;
      expData  = '0;
    end else begin
      expValid = 1'b0;
      if (mq.size() > 0 && mq[0].done) begin
        expValid = 1'b1;
        expTag   = mq[0].tag;
        expDest  = mq[0].dest;
        expData  = mq[0].data;
        void'(mq.pop_front());
      end
      if (cdb_valid) begin
        foreach (mq[k]) begin
          if (mq[k].tag == int'(cdb_tag)) begin
            mq[k].done = 1'b1;
            mq[k].data = cdb_data;
          end
        end
      end
      if (issue_valid && sizeBefore < ROB_DEPTH) begin
        e.tag  = nextTag;
        e.dest = issue_dest;
        e.done = 1'b0;
        e.data = '0;
        mq.push_back(e);
        nextTag = (nextTag + 1) % ROB_DEPTH;
      end
    end
  endtask

  task automatic checkOutput();
    checkVal("count",        32'(count),        32'(mq.size()));
    checkVal("full",         32'(full),         32'(mq.size() == ROB_DEPTH));
    checkVal("empty",        32'(empty),        32'(mq.size() == 0));
    checkVal("issue_ready",  32'(issue_ready),  32'(mq.size() != ROB_DEPTH));
    checkVal("issue_tag",    32'(issue_tag),    32'(nextTag));
    checkVal("commit_valid", 32'(commit_valid), 32'(expValid));
    checkVal("commit_tag",   32'(commit_tag),   32'(expTag));
    checkVal("commit_dest",  32'(commit_dest),  32'(expDest));
    checkVal("commit_data",  32'(commit_data),  32'(expData));
    if (commit_valid === 1'b1) commitLog.push_back(int'(commit_tag));
  endtask

  task automatic applyStimulus(input logic iv, input logic [REG_W-1:0] idst,
                               input logic cv, input logic [TAG_W-1:0] ct,
                               input logic [DATA_W-1:0] cd, input logic fl);
    issue_valid = iv;
    issue_dest  = idst;
    cdb_valid   = cv;
    cdb_tag     = ct;
    cdb_data    = cd;
    flush       = fl;
    @(posedge clk1);
    modelEdge();
    #1;
    checkOutput();
    issue_valid = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; issue_valid = 1'b0; issue_dest = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; flush = 1'b0;
    nextTag = 0; expValid = 1'b0; expTag = 0; expDest = '0; expData = '0;
    #2;

    // Reset state pinned with literals.
    doReset();
    checkVal("rst_empty", 32'(empty), 32'd1);
    checkVal("rst_count", 32'(count), 32'd0);
    checkVal("rst_ready", 32'(issue_ready), 32'd1);
    checkVal("rst_tag",   32'(issue_tag), 32'd0);
    checkVal("rst_cv",    32'(commit_valid), 32'd0);

    // Fill to full, then one ignored issue.
    for (int i = 0; i < 8; i++) begin
      checkVal("fill_tag", 32'(issue_tag), 32'(i));
      applyStimulus(1'b1, REG_W'(i + 1), 1'b0, '0, '0, 1'b0);
    end
    checkVal("fill_full",  32'(full), 32'd1);
    checkVal("fill_ready", 32'(issue_ready), 32'd0);
    applyStimulus(1'b1, 4'hF, 1'b0, '0, '0, 1'b0);
    checkVal("fill_count9", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b1, TAG_W'(i), DATA_W'(16'h100 + i), 1'b0);
    idle(2);
    checkVal("drain_empty", 32'(empty), 32'd1);

    // Out-of-order completion, in-order retirement.
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, REG_W'(i + 3), 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 3'd2, 16'h0022, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 3'd1, 16'h0011, 1'b0);
    idle(1);
    checkVal("ooo_nocommit", 32'(commit_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 3'd0, 16'h0000, 1'b0);
    checkVal("ooo_nobypass", 32'(commit_valid), 32'd0);
    idle(1);
    checkVal("ooo_c0_tag",  32'(commit_tag), 32'd0);
    checkVal("ooo_c0_dest", 32'(commit_dest), 32'd3);
    idle(1);
    checkVal("ooo_c1_data", 32'(commit_data), 32'h11);
    checkVal("ooo_c1_dest", 32'(commit_dest), 32'd4);
    idle(1);
    checkVal("ooo_c2_data", 32'(commit_data), 32'h22);
    checkVal("ooo_c2_tag",  32'(commit_tag), 32'd2);
    checkVal("ooo_empty",   32'(empty), 32'd1);

    // Streamed wrap-around: 12 instructions, commit order 0..7,0..3.
    doReset();
    commitLog.delete();
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, REG_W'(i), i > 0, TAG_W'((i + 7) % 8), DATA_W'(i * 7), 1'b0);
    applyStimulus(1'b0, '0, 1'b1, TAG_W'(11 % 8), 16'h0BAD, 1'b0);
    idle(3);
    checkVal("wrap_ncommits", 32'(commitLog.size()), 32'd12);
    for (int i = 0; i < 12 && i < commitLog.size(); i++)
      checkVal("wrap_order", 32'(commitLog[i]), 32'(i % 8));
    checkVal("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous issue and commit; CDB to an unallocated tag.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, REG_W'(i + 9), 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 3'd0, 16'h0050, 1'b0);
    applyStimulus(1'b1, 4'd14, 1'b0, '0, '0, 1'b0);
    checkVal("sim_count", 32'(count), 32'd4);
    checkVal("sim_cv",    32'(commit_valid), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 3'd5, 16'hDEAD, 1'b0);
    checkVal("free_count", 32'(count), 32'd4);
    applyStimulus(1'b1, 4'd2, 1'b0, '0, '0, 1'b0);
    idle(2);
    checkVal("free_nocommit", 32'(commit_valid), 32'd0);

    // Flush with CDB on the same edge, then a stale CDB.
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, REG_W'(i), 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b1, 4'd7, 1'b1, 3'd1, 16'h1234, 1'b1);
    checkVal("flush_empty", 32'(empty), 32'd1);
    checkVal("flush_cv",    32'(commit_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 3'd3, 16'h3333, 1'b0);
    checkVal("flush_count", 32'(count), 32'd0);
    checkVal("flush_tag",   32'(issue_tag), 32'd0);
    applyStimulus(1'b1, 4'd6, 1'b0, '0, '0, 1'b0);
    idle(2);
    checkVal("flush_nocommit", 32'(commit_valid), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic              iv, cv, fl;
      logic [TAG_W-1:0]  ct;
      rst_n = ($urandom_range(0, 299) != 0);
      iv = ($urandom_range(0, 99) < 55);
      cv = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 149) == 0);
      if (mq.size() > 0 && $urandom_range(0, 99) < 75)
        ct = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else
        ct = TAG_W'($urandom_range(0, ROB_DEPTH - 1));
      applyStimulus(iv, REG_W'($urandom), cv, ct, DATA_W'($urandom), fl);
    end
    rst_n = 1'b1;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
